// File: rtl/ob_bank_reader_if.sv
// Request, RAM read port and TX stream of the outbound bank reader.
// slave = reader side, master = requester / RAM / downstream side.
interface ob_bank_reader_if #(
  parameter int DATA_W = 128
);
  logic              ReqValid;
  logic              ReqReady;
  logic [2:0]        ReqBank;
  logic [7:0]        ReqRow;
  logic [8:0]        ReqBeats;
  logic              RdEn;
  logic [31:0]       RdAddr;
  logic [DATA_W-1:0] RdData;
  logic              TxValid;
  logic              TxReady;
  logic [DATA_W-1:0] TxData;
  logic              TxLast;
  logic              Done;
  logic [2:0]        DoneBank;

  modport slave (
    input  ReqValid, ReqBank, ReqRow, ReqBeats, RdData, TxReady,
    output ReqReady, RdEn, RdAddr, TxValid, TxData, TxLast, Done, DoneBank
  );

  modport master (
    output ReqValid, ReqBank, ReqRow, ReqBeats, RdData, TxReady,
    input  ReqReady, RdEn, RdAddr, TxValid, TxData, TxLast, Done, DoneBank
  );
endinterface

// File: rtl/ob_bank_reader.sv
// Drains one bank of the outbound RAM onto a valid/ready TX stream; first beat 2 cycles after accept.
// Reads are credit-limited so the output buffer never overflows while TxReady is low.
module ob_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pushVld,
  input  logic [WIDTH-1:0]       pushDat,
  input  logic                   popRdy,
  output logic                   popVld,
  output logic [WIDTH-1:0]       popDat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [AW:0]      cnt;
  logic             doPop;

  assign popVld = (cnt != '0);
  assign popDat = mem[rdPtr];
  assign count  = cnt;
  assign doPop  = popVld & popRdy;

  always_ff @(posedge clk) begin
    if (pushVld) begin
      mem[wrPtr] <= pushDat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else begin
      if (pushVld) begin
        wrPtr <= wrPtr + AW'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + AW'(1);
      end
      case ({pushVld, doPop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module ob_bank_reader #(
  parameter int DATA_W     = 128,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  ob_bank_reader_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} stateT;

  stateT             state;
  stateT             stateNext;
  logic              armed;
  logic [2:0]        bankQ;
  logic [7:0]        rowQ;
  logic [8:0]        beatsQ;
  logic [8:0]        issued;
  logic [8:0]        popped;
  logic              rdPending;

  logic              reqReady;
  logic              accept;
  logic [8:0]        clampBeats;
  logic              rdEn;
  logic              creditOk;
  logic [CW:0]       occupancy;
  logic              done;

  logic [CW-1:0]     fifoCount;
  logic              fifoVld;
  logic [DATA_W-1:0] fifoDat;
  logic              fifoPush;
  logic              txValid;
  logic              txPop;
  logic              bypass;
  logic              lastBeat;
  logic [DATA_W-1:0] txData;

  assign accept     = bus.ReqValid & reqReady;
  assign clampBeats = bus.ReqBeats[8] ? 9'd256 : bus.ReqBeats;

  // RdData arriving this cycle goes straight to the stream when the buffer is empty.
  assign txValid  = fifoVld | rdPending;
  assign txPop    = txValid & bus.TxReady;
  assign bypass   = ~fifoVld & rdPending;
  assign fifoPush = rdPending & ~(bypass & bus.TxReady);
  assign txData   = fifoVld ? fifoDat : (rdPending ? bus.RdData : '0);
  assign lastBeat = ((popped + 9'd1) == beatsQ);

  // Entries held after this cycle; a new read is allowed only if its data will fit.
  assign occupancy = {1'b0, fifoCount} + (CW+1)'(rdPending) - (CW+1)'(txPop);
  assign creditOk  = (occupancy < (CW+1)'(FIFO_DEPTH));
  assign rdEn      = (state == READ) && (issued != beatsQ) && creditOk;

  ob_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) outBuf (
    .clk     (clk),
    .rst     (rst),
    .pushVld (fifoPush),
    .pushDat (bus.RdData),
    .popRdy  (bus.TxReady),
    .popVld  (fifoVld),
    .popDat  (fifoDat),
    .count   (fifoCount)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      armed     <= 1'b0;
      bankQ     <= '0;
      rowQ      <= '0;
      beatsQ    <= '0;
      issued    <= '0;
      popped    <= '0;
      rdPending <= 1'b0;
    end else begin
      state     <= stateNext;
      armed     <= 1'b1;
      rdPending <= rdEn;
      if (accept) begin
        bankQ  <= bus.ReqBank;
        rowQ   <= bus.ReqRow;
        beatsQ <= clampBeats;
        issued <= '0;
        popped <= '0;
      end
      if (rdEn) begin
        rowQ   <= rowQ + 8'd1;
        issued <= issued + 9'd1;
      end
      if (txPop) begin
        popped <= popped + 9'd1;
      end
    end
  end

  always_comb begin
    stateNext = state;
    reqReady  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        reqReady = armed;
        if (accept) begin
          stateNext = (clampBeats == 9'd0) ? FIN : READ;
        end
      end
      READ: begin
        if (rdEn && ((issued + 9'd1) == beatsQ)) begin
          stateNext = DRAIN;
        end
      end
      DRAIN: begin
        if (txPop && lastBeat) begin
          stateNext = FIN;
        end
      end
      FIN: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign bus.ReqReady = reqReady;
  assign bus.RdEn     = rdEn;
  assign bus.RdAddr   = rdEn ? {20'h0, 1'b0, bankQ, rowQ} : 32'h0;
  assign bus.TxValid  = txValid;
  assign bus.TxData   = txData;
  assign bus.TxLast   = txValid & lastBeat;
  assign bus.Done     = done;
  assign bus.DoneBank = done ? bankQ : 3'd0;

  noOverflow: assert property (@(posedge clk) disable iff (rst)
    fifoPush |-> ((fifoCount < CW'(FIFO_DEPTH)) || (fifoVld && bus.TxReady)));
endmodule

// File: tb/tb_ob_bank_reader.sv
// Directed bench for ob_bank_reader: RAM model, stream monitor, hand-computed expectations.
module tb_ob_bank_reader;
  localparam int DATA_W = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   nCompared = 0;
  int   nMismatched = 0;
  int   acc;

  logic [31:0]       rdAddrQ[$];
  int                rdCycQ[$];
  logic [DATA_W-1:0] txDatQ[$];
  logic              txLastQ[$];
  int                txCycQ[$];
  int                doneCycQ[$];
  logic [2:0]        doneBankQ[$];

  ob_bank_reader_if #(.DATA_W(DATA_W)) bus ();

  ob_bank_reader #(.DATA_W(DATA_W), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] ramWord(input logic [31:0] addr);
    return {4{20'hA5C3E, addr[11:0]}};
  endfunction

  // RAM: data valid the cycle after RdEn, junk otherwise.
  always @(posedge clk) begin
    if (bus.RdEn) bus.RdData <= ramWord(bus.RdAddr);
    else          bus.RdData <= {4{32'hDEADBEEF}};
  end

  always @(negedge clk) begin
    if (bus.RdEn) begin
      rdAddrQ.push_back(bus.RdAddr);
      rdCycQ.push_back(cyc);
    end
    if (bus.TxValid && bus.TxReady) begin
      txDatQ.push_back(bus.TxData);
      txLastQ.push_back(bus.TxLast);
      txCycQ.push_back(cyc);
    end
    if (bus.Done) begin
      doneCycQ.push_back(cyc);
      doneBankQ.push_back(bus.DoneBank);
    end
  end

  task automatic checkVal(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearLogs();
    rdAddrQ.delete(); rdCycQ.delete();
    txDatQ.delete(); txLastQ.delete(); txCycQ.delete();
    doneCycQ.delete(); doneBankQ.delete();
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, "_reqready"}, bus.ReqReady, 0);
    checkVal({tag, "_rden"},     bus.RdEn, 0);
    checkVal({tag, "_rdaddr"},   bus.RdAddr, 0);
    checkVal({tag, "_txvalid"},  bus.TxValid, 0);
    checkVal({tag, "_txdata"},   bus.TxData, 0);
    checkVal({tag, "_txlast"},   bus.TxLast, 0);
    checkVal({tag, "_done"},     bus.Done, 0);
    checkVal({tag, "_donebank"}, bus.DoneBank, 0);
  endtask

  task automatic sendReq(input logic [2:0] bank, input logic [7:0] row, input logic [8:0] beats, output int accCyc);
    int n = 0;
    bus.ReqBank  = bank;
    bus.ReqRow   = row;
    bus.ReqBeats = beats;
    bus.ReqValid = 1'b1;
    while (!bus.ReqReady && n < 50) begin
      tick(1);
      n++;
    end
    if (!bus.ReqReady) checkVal("req_timeout", 0, 1);
    accCyc = cyc;
    tick(1);
    bus.ReqValid = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (doneCycQ.size() < 1 && n < budget) begin
      tick(1);
      n++;
    end
    if (doneCycQ.size() < 1) checkVal("done_timeout", 0, 1);
  endtask

  task automatic checkRun(input string tag, input logic [2:0] bank, input logic [7:0] row,
                          input int beats, input int accCyc, input bit timed);
    logic [31:0] a;
    checkVal({tag, "_nrd"},   rdAddrQ.size(), beats);
    checkVal({tag, "_ntx"},   txDatQ.size(), beats);
    checkVal({tag, "_ndone"}, doneCycQ.size(), 1);
    if (doneBankQ.size() > 0) checkVal({tag, "_donebank"}, doneBankQ[0], bank);
    for (int i = 0; i < beats; i++) begin
      a = {20'h0, 1'b0, bank, row + 8'(i)};
      if (i < rdAddrQ.size()) checkVal({tag, "_addr"}, rdAddrQ[i], a);
      if (i < txDatQ.size()) begin
        checkVal({tag, "_data"}, txDatQ[i], ramWord(a));
        checkVal({tag, "_last"}, txLastQ[i], (i == beats - 1));
      end
      if (timed && i < rdCycQ.size()) checkVal({tag, "_rdcyc"}, rdCycQ[i], accCyc + 1 + i);
      if (timed && i < txCycQ.size()) checkVal({tag, "_txcyc"}, txCycQ[i], accCyc + 2 + i);
    end
    if (timed && doneCycQ.size() > 0) checkVal({tag, "_donecyc"}, doneCycQ[0], accCyc + beats + 2);
  endtask

  initial begin
    int n;
    bus.ReqValid = 1'b0;
    bus.ReqBank  = '0;
    bus.ReqRow   = '0;
    bus.ReqBeats = '0;
    bus.TxReady  = 1'b0;
    rst = 1'b1;
    tick(3);
    checkAllZero("reset");
    rst = 1'b0;
    checkVal("rdy_during_release", bus.ReqReady, 0);
    tick(1);
    checkVal("rdy_after_release", bus.ReqReady, 1);

    // Basic 4-beat read, full throughput
    bus.TxReady = 1'b1;
    clearLogs();
    sendReq(3'd3, 8'h10, 9'd4, acc);
    waitDone(100);
    checkRun("t1", 3'd3, 8'h10, 4, acc, 1);
    checkVal("t1_rdy_again", bus.ReqReady, 1);

    // Row wrap stays inside the bank
    clearLogs();
    sendReq(3'd7, 8'hFE, 9'd4, acc);
    waitDone(100);
    checkRun("t2", 3'd7, 8'hFE, 4, acc, 1);
    if (rdAddrQ.size() > 2) checkVal("t2_wrap_addr", rdAddrQ[2], 32'h700);

    // Backpressure: credit stops reads at buffer depth, head beat held
    bus.TxReady = 1'b0;
    clearLogs();
    sendReq(3'd5, 8'h20, 9'd10, acc);
    tick(20);
    checkVal("t3_stall_nrd", rdAddrQ.size(), 4);
    checkVal("t3_hold_vld",  bus.TxValid, 1);
    checkVal("t3_hold_data", bus.TxData, ramWord(32'h520));
    checkVal("t3_hold_last", bus.TxLast, 0);
    bus.TxReady = 1'b1;
    waitDone(200);
    checkRun("t3", 3'd5, 8'h20, 10, acc, 0);

    // Whole bank under random backpressure
    clearLogs();
    bus.TxReady = 1'($urandom_range(0, 1));
    sendReq(3'd0, 8'h00, 9'd256, acc);
    n = 0;
    while (doneCycQ.size() < 1 && n < 3000) begin
      bus.TxReady = 1'($urandom_range(0, 1));
      tick(1);
      n++;
    end
    bus.TxReady = 1'b1;
    waitDone(50);
    checkRun("t4", 3'd0, 8'h00, 256, acc, 0);

    // Zero-beat request completes immediately
    clearLogs();
    sendReq(3'd2, 8'h44, 9'd0, acc);
    waitDone(20);
    checkVal("t5_nrd", rdAddrQ.size(), 0);
    checkVal("t5_ntx", txDatQ.size(), 0);
    if (doneCycQ.size() > 0) checkVal("t5_donecyc", doneCycQ[0], acc + 1);
    if (doneBankQ.size() > 0) checkVal("t5_donebank", doneBankQ[0], 3'd2);

    // Oversized beat count reads one full bank
    clearLogs();
    sendReq(3'd4, 8'h80, 9'd300, acc);
    waitDone(400);
    checkRun("clamp", 3'd4, 8'h80, 256, acc, 1);

    // Reset in the middle of a request
    clearLogs();
    sendReq(3'd1, 8'h00, 9'd8, acc);
    n = 0;
    while (txDatQ.size() < 3 && n < 50) begin
      tick(1);
      n++;
    end
    checkVal("t6_reach3", (txDatQ.size() >= 3), 1);
    rst = 1'b1;
    tick(1);
    checkAllZero("t6_abort");
    tick(1);
    rst = 1'b0;
    checkVal("t6_rdy_low", bus.ReqReady, 0);
    tick(3);
    checkVal("t6_nodone", doneCycQ.size(), 0);
    checkVal("t6_idle_txvalid", bus.TxValid, 0);
    clearLogs();
    sendReq(3'd6, 8'h33, 9'd2, acc);
    waitDone(50);
    checkRun("t6b", 3'd6, 8'h33, 2, acc, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
